// File: rtl/pc_unit_stack_if.sv
// Control-unit-to-PC interface: per-edge control strobes in, registered PC and
// stack/fault status out.
interface pc_unit_stack_if #(
  parameter int PC_WIDTH  = 28,
  parameter int OFF_WIDTH = 12
);
  // Strobes are plain level commands sampled on every fetch edge (no valid/ready
  // handshake): the PC unit is always ready, so a strobe high at an edge is
  // consumed at that edge, and outputs are valid from just after that edge.
  logic                 incpc;
  logic                 jump;
  logic                 branch;
  logic                 call;
  logic                 ret;
  logic [PC_WIDTH-1:0]  jumpaddr;
  logic [OFF_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0]  pcout;
  logic                 stack_full;
  logic                 stack_empty;
  logic [2:0]           fault;

  modport master (
    output incpc, jump, branch, call, ret, jumpaddr, offset,
    input  pcout, stack_full, stack_empty, fault
  );

  modport slave (
    input  incpc, jump, branch, call, ret, jumpaddr, offset,
    output pcout, stack_full, stack_empty, fault
  );
endinterface

// File: rtl/pc_unit_stack.sv
// Fetch-stage program counter with wrap limit, jump/branch, and call/return via
// an internal return-address stack; sticky overflow/underflow/range flags.
module pc_unit_stack #(
  parameter int PC_WIDTH     = 28,
  parameter int MAX_PC       = 255,
  parameter int RESET_VECTOR = 0,
  parameter int OFF_WIDTH    = 12,
  parameter int STACK_DEPTH  = 4
) (
  input  logic            fetch,
  input  logic            resetn,
  pc_unit_stack_if.slave  bus
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SW = PC_WIDTH + 2;

  localparam logic [PC_WIDTH-1:0] MAX_V   = PC_WIDTH'(MAX_PC);
  localparam logic [PC_WIDTH-1:0] RV      = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PW-1:0]       DEPTH_V = PW'(STACK_DEPTH);
  localparam logic [PW-1:0]       ONE     = PW'(1);

  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PW-1:0]       ptr, ptr_nxt;
  logic [2:0]          fault, fault_nxt;
  logic [PC_WIDTH-1:0] stk [STACK_DEPTH];

  logic                push;
  logic [IW-1:0]       wr_idx, rd_idx;
  logic [PC_WIDTH-1:0] ret_addr, top_val, succ;
  logic [SW-1:0]       br_sum;
  logic                at_max, ja_ok, br_ok, full, empty;

  assign full   = (ptr == DEPTH_V);
  assign empty  = (ptr == '0);
  assign at_max = (pc >= MAX_V);
  assign succ   = at_max ? RV : pc + PC_WIDTH'(1);
  assign ja_ok  = (bus.jumpaddr <= MAX_V);

  // Two guard bits keep the sign of the sum unambiguous for any offset/PC mix.
  assign br_sum = {2'b00, pc} + {{(SW-OFF_WIDTH){bus.offset[OFF_WIDTH-1]}}, bus.offset};
  assign br_ok  = !br_sum[SW-1] && (br_sum <= {2'b00, MAX_V});

  assign wr_idx   = IW'(ptr);
  assign rd_idx   = IW'(ptr - ONE);
  assign top_val  = stk[rd_idx];
  assign ret_addr = succ;

  always_comb begin
    pc_nxt    = pc;
    ptr_nxt   = ptr;
    fault_nxt = fault;
    push      = 1'b0;
    if (bus.ret) begin
      if (empty) begin
        fault_nxt[1] = 1'b1;
      end else begin
        pc_nxt  = top_val;
        ptr_nxt = ptr - ONE;
      end
    end else if (bus.call) begin
      if (full) begin
        fault_nxt[0] = 1'b1;
      end else if (!ja_ok) begin
        fault_nxt[2] = 1'b1;
      end else begin
        push    = 1'b1;
        ptr_nxt = ptr + ONE;
        pc_nxt  = bus.jumpaddr;
      end
    end else if (bus.jump) begin
      if (ja_ok) pc_nxt = bus.jumpaddr;
      else       fault_nxt[2] = 1'b1;
    end else if (bus.branch) begin
      if (br_ok) pc_nxt = br_sum[PC_WIDTH-1:0];
      else       fault_nxt[2] = 1'b1;
    end else if (bus.incpc) begin
      pc_nxt = succ;
    end
  end

  always_ff @(posedge fetch or negedge resetn) begin
    if (!resetn) begin
      pc    <= RV;
      ptr   <= '0;
      fault <= 3'b000;
    end else begin
      pc    <= pc_nxt;
      ptr   <= ptr_nxt;
      fault <= fault_nxt;
    end
  end

  // Stack contents need no reset; only the pointer defines what is live.
  always_ff @(posedge fetch) begin
    if (push) stk[wr_idx] <= ret_addr;
  end

  assign bus.pcout       = pc;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.fault       = fault;

endmodule

// File: tb/tb_pc_unit_stack.sv
// Directed bench for pc_unit_stack: a behavioural model with a queue-based
// return stack is compared every cycle, plus hand-computed pinned values.
module tb_pc_unit_stack;

  localparam int PC_WIDTH    = 28;
  localparam int OFF_WIDTH   = 12;
  localparam int MAX_PC      = 255;
  localparam int RV          = 0;
  localparam int STACK_DEPTH = 4;

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_INC  = 5'b00001;
  localparam logic [4:0] S_BR   = 5'b00010;
  localparam logic [4:0] S_JMP  = 5'b00100;
  localparam logic [4:0] S_CALL = 5'b01000;
  localparam logic [4:0] S_RET  = 5'b10000;

  logic fetch;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  bit   run   = 0;

  pc_unit_stack_if #(.PC_WIDTH(PC_WIDTH), .OFF_WIDTH(OFF_WIDTH)) bus ();

  pc_unit_stack #(
    .PC_WIDTH(PC_WIDTH), .MAX_PC(MAX_PC), .RESET_VECTOR(RV),
    .OFF_WIDTH(OFF_WIDTH), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .fetch  (fetch),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  initial begin
    fetch = 1'b0;
    forever #5 fetch = ~fetch;
  end

  // behavioural model: PC as an integer, return stack as a queue
  int                  m_pc    = RV;
  logic [2:0]          m_fault = 3'b000;
  logic [PC_WIDTH-1:0] exp_q[$];

  always @(posedge fetch or negedge resetn) begin
    if (!resetn) begin
      m_pc    = RV;
      m_fault = 3'b000;
      exp_q.delete();
    end else begin
      int    ra;
      longint t;
      ra = (m_pc >= MAX_PC) ? RV : m_pc + 1;
      if (bus.ret) begin
        if (exp_q.size() == 0) m_fault[1] = 1'b1;
        else                   m_pc = int'(exp_q.pop_back());
      end else if (bus.call) begin
        if (exp_q.size() == STACK_DEPTH)       m_fault[0] = 1'b1;
        else if (int'(bus.jumpaddr) > MAX_PC)  m_fault[2] = 1'b1;
        else begin
          exp_q.push_back(PC_WIDTH'(ra));
          m_pc = int'(bus.jumpaddr);
        end
      end else if (bus.jump) begin
        if (int'(bus.jumpaddr) <= MAX_PC) m_pc = int'(bus.jumpaddr);
        else                              m_fault[2] = 1'b1;
      end else if (bus.branch) begin
        t = longint'(m_pc) + longint'($signed(bus.offset));
        if (t < 0 || t > MAX_PC) m_fault[2] = 1'b1;
        else                     m_pc = int'(t);
      end else if (bus.incpc) begin
        m_pc = ra;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle outside reset, DUT vs model
  always @(negedge fetch) begin
    if (run && resetn) begin
      check("model_pc",    32'(bus.pcout),       32'(m_pc));
      check("model_full",  32'(bus.stack_full),  32'(exp_q.size() == STACK_DEPTH));
      check("model_empty", 32'(bus.stack_empty), 32'(exp_q.size() == 0));
      check("model_fault", 32'(bus.fault),       32'(m_fault));
    end
  end

  // driver tasks
  task automatic step(input logic [4:0] s, input logic [27:0] ja, input logic [11:0] off);
    @(negedge fetch);
    #1;
    {bus.ret, bus.call, bus.jump, bus.branch, bus.incpc} = s;
    bus.jumpaddr = ja;
    bus.offset   = off;
    @(posedge fetch);
    #1;
  endtask

  task automatic pin(input string name, input int pc, input bit e, input bit f, input logic [2:0] flt);
    check({name, "_pc"},    32'(bus.pcout),       32'(pc));
    check({name, "_empty"}, 32'(bus.stack_empty), 32'(e));
    check({name, "_full"},  32'(bus.stack_full),  32'(f));
    check({name, "_fault"}, 32'(bus.fault),       32'(flt));
  endtask

  initial begin
    resetn = 1'b0;
    {bus.ret, bus.call, bus.jump, bus.branch, bus.incpc} = S_IDLE;
    bus.jumpaddr = '0;
    bus.offset   = '0;
    #12 resetn = 1'b1;
    #1;
    pin("reset", 0, 1, 0, 3'b000);
    run = 1;

    for (int k = 1; k <= 256; k++) begin
      step(S_INC, 28'h0, 12'h0);
      if (k == 128) pin("inc128", 128, 1, 0, 3'b000);
      if (k == 255) pin("inc255", 255, 1, 0, 3'b000);
      if (k == 256) pin("inc_wrap", 0, 1, 0, 3'b000);
    end

    step(S_JMP, 28'h40, 12'h0);   pin("jump40", 'h40, 1, 0, 3'b000);
    step(S_BR,  28'h0, 12'hFF0);  pin("br_m16", 'h30, 1, 0, 3'b000);
    step(S_BR,  28'h0, 12'hFC0);  pin("br_neg", 'h30, 1, 0, 3'b100);

    step(S_JMP,  28'h10, 12'h0);  pin("jump10", 'h10, 1, 0, 3'b100);
    step(S_CALL, 28'h80, 12'h0);  pin("call80", 'h80, 0, 0, 3'b100);
    step(S_CALL, 28'h90, 12'h0);  pin("call90", 'h90, 0, 0, 3'b100);
    step(S_RET,  28'h0, 12'h0);   pin("ret1",   'h81, 0, 0, 3'b100);
    step(S_RET,  28'h0, 12'h0);   pin("ret2",   'h11, 1, 0, 3'b100);

    step(S_JMP,  28'h10, 12'h0);
    step(S_CALL, 28'h20, 12'h0);
    step(S_CALL, 28'h30, 12'h0);
    step(S_CALL, 28'h40, 12'h0);
    step(S_CALL, 28'h50, 12'h0);  pin("fill4", 'h50, 0, 1, 3'b100);
    step(S_CALL, 28'h20, 12'h0);  pin("ovf",   'h50, 0, 1, 3'b101);
    step(S_RET,  28'h0, 12'h0);   pin("drain1", 'h41, 0, 0, 3'b101);
    step(S_RET,  28'h0, 12'h0);   pin("drain2", 'h31, 0, 0, 3'b101);
    step(S_RET,  28'h0, 12'h0);   pin("drain3", 'h21, 0, 0, 3'b101);
    step(S_RET,  28'h0, 12'h0);   pin("drain4", 'h11, 1, 0, 3'b101);
    step(S_RET,  28'h0, 12'h0);   pin("unf",    'h11, 1, 0, 3'b111);

    step(S_CALL | S_INC, 28'h60, 12'h0);          pin("call_inc", 'h60, 0, 0, 3'b111);
    step(S_RET | S_JMP, 28'h70, 12'h0);           pin("ret_jmp",  'h12, 1, 0, 3'b111);
    step(S_JMP | S_BR | S_INC, 28'h33, 12'h005);  pin("jmp_br",   'h33, 1, 0, 3'b111);
    step(S_BR | S_INC, 28'h0, 12'h002);           pin("br_inc",   'h35, 1, 0, 3'b111);
    step(S_CALL, 28'h30, 12'h0);                  pin("call_pre", 'h30, 0, 0, 3'b111);
    step(S_IDLE, 28'h0, 12'h0);                   pin("hold",     'h30, 0, 0, 3'b111);

    // asynchronous reset between edges, fetch still high
    #2 resetn = 1'b0;
    #1;
    pin("async_rst", 0, 1, 0, 3'b000);
    @(posedge fetch);
    #1;
    pin("rst_held", 0, 1, 0, 3'b000);
    @(negedge fetch);
    #2 resetn = 1'b1;

    step(S_JMP,  28'hFF, 12'h0);  pin("jmp_max",  'hFF, 1, 0, 3'b000);
    step(S_CALL, 28'h05, 12'h0);  pin("call_max", 'h05, 0, 0, 3'b000);
    step(S_RET,  28'h0, 12'h0);   pin("ret_wrap", 'h00, 1, 0, 3'b000);
    step(S_JMP,  28'hF0, 12'h0);
    step(S_BR,   28'h0, 12'h00F); pin("br_tomax", 'hFF, 1, 0, 3'b000);
    step(S_BR,   28'h0, 12'h001); pin("br_over",  'hFF, 1, 0, 3'b100);
    step(S_INC,  28'h0, 12'h0);   pin("inc_wrap2", 'h00, 1, 0, 3'b100);
    step(S_JMP,  28'h100, 12'h0); pin("jmp_range", 'h00, 1, 0, 3'b100);
    step(S_IDLE, 28'h0, 12'h0);
    @(negedge fetch);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
